// File: rtl/clod_pim_match_scanner.sv
// clod_pim_match_scanner: turns each accepted row match vector into a serial
// stream of matching element indices, lowest first, one record per cycle.
// Rows with no match yield a single miss record so every row terminates.
module clod_pim_match_scanner #(
    parameter int num_row_elements = 256,
    parameter int row_addr_width   = 16,
    localparam int idx_w           = $clog2(num_row_elements)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [row_addr_width-1:0]   in_row_addr,
    input  logic [num_row_elements-1:0] in_match_bits,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [row_addr_width-1:0]   out_row_addr,
    output logic [idx_w-1:0]            out_idx,
    output logic                        out_hit,
    output logic                        out_last,
    output logic [idx_w:0]              hit_count,
    output logic                        busy
);

    localparam logic [idx_w:0] hc_max = (idx_w+1)'(num_row_elements);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                      state, state_nxt;
    logic [num_row_elements-1:0] residual;
    logic [num_row_elements-1:0] lowbit;
    logic [num_row_elements-1:0] rest;
    logic [row_addr_width-1:0]   row_q;
    logic [idx_w:0]              hc_q;
    logic [idx_w-1:0]            enc;
    logic                        load;
    logic                        adv;

    // Isolate the lowest set bit and the vector with that bit removed; the
    // carry chain maps well onto fast adders, leaving only an OR tree to encode.
    assign lowbit = residual & (~residual + 1'b1);
    assign rest   = residual & (residual - 1'b1);

    // Encode the one-hot lowest bit; an all-zero residual yields index 0.
    always_comb begin
        enc = '0;
        for (int i = 0; i < num_row_elements; i++) begin
            if (lowbit[i]) enc = enc | idx_w'(i);
        end
    end

    assign out_row_addr = row_q;
    assign out_idx      = enc;
    assign out_hit      = |residual;
    assign out_last     = ~|rest;
    assign hit_count    = hc_q;

    // Next-state and handshake control; everything is suppressed during reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    adv = 1'b1;
                    if (out_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
            load      = 1'b0;
            adv       = 1'b0;
        end
    end

    // State, residual vector, row tag and hit counter; residual only moves on
    // a handshake, which keeps every out_* field stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            residual <= '0;
            row_q    <= '0;
            hc_q     <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                residual <= in_match_bits;
                row_q    <= in_row_addr;
                hc_q     <= '0;
            end else if (adv) begin
                residual <= rest;
                if (out_hit && hc_q != hc_max) hc_q <= hc_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/clod_pim_match_scanner.md
Name: clod_pim_match_scanner

Overview:
- Consumes the per-row match vector from the CLoD PiM match logic. It sits in parallel with, and downstream of, the same source as the row-level any-match OR.
- Converts each accepted match vector into a serial stream of matching element indices, lowest index first, one per cycle, under valid/ready flow control.
- Rows with no match produce a single miss record, so the host-side collector always receives exactly one terminating record per row.

Parameters:
- num_row_elements, 256: number of elements in a DRAM sub-array row, i.e. the match vector width. Must be a power of two and at least 2.
- row_addr_width, 16: width of the row address tag carried with each vector.
- Derived localparam idx_w = $clog2(num_row_elements).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  match vector and row address are valid.
- in_ready  output  1  scanner can accept a vector.
- in_row_addr  input  row_addr_width  row address tag of the vector.
- in_match_bits  input  num_row_elements  match bits; bit i set means element i matched.
- out_valid  output  1  record is valid.
- out_ready  input  1  downstream accepts the record.
- out_row_addr  output  row_addr_width  row tag of the current record.
- out_idx  output  idx_w  index of the matching element; 0 on a miss record.
- out_hit  output  1  1 = match record, 0 = miss record.
- out_last  output  1  final record for this row.
- hit_count  output  idx_w+1  number of match records handshaken for the current or most recent row.
- busy  output  1  high while in SCAN.

Behaviour:
- Reset values: state IDLE; residual vector, row register and hit_count all 0.
- During reset: out_valid=0, busy=0, in_ready=0.
- The first cycle after rst deasserts has in_ready=1.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: register in_match_bits into the residual vector and in_row_addr into the row register, clear hit_count to 0, and go to SCAN.
- State SCAN:
  - in_ready=0; in_valid is ignored, and the upstream holds its request until IDLE.
  - out_valid=1; busy=1.
  - out_row_addr = row register.
  - out_hit = |residual.
  - out_idx = position of the lowest set bit of residual, or 0 if residual is 0.
  - out_last = 1 if residual has zero or exactly one bit set.
- Handshake in SCAN (out_valid & out_ready):
  - Clear the lowest set bit of residual.
  - If out_hit, increment hit_count.
  - If out_last, return to IDLE.
- Output stability: while out_valid & !out_ready, every out_* field holds constant, because residual changes only on a handshake.
- Latency and throughput:
  - The first record is valid the cycle after input acceptance.
  - One record per cycle under continuous out_ready.
  - One IDLE bubble cycle between rows, so a row with k hits occupies k+1 cycles minimum; a miss row occupies 2.
- hit_count saturation and hold:
  - hit_count never wraps; its maximum is num_row_elements, which fits in idx_w+1 bits.
  - It holds its value in IDLE until the next acceptance.
- Boundary conditions:
  - All-zero vector: exactly one record with hit=0, idx=0, last=1.
  - Single bit at num_row_elements-1: one record with idx=num_row_elements-1, hit=1, last=1.
  - All-ones vector: num_row_elements records with idx 0..N-1; last=1 only on N-1.
- Reset mid-scan: the row is abandoned. No further records are emitted, and hit_count and residual clear. A partially delivered row is not resumed.
- The priority encoder is combinational on residual. Implementation chooses the structure, but timing must close at the codebase target for num_row_elements=256.

Test Plan:
- Default params; input row 0x0012 with bits {3,7,200} set and out_ready tied 1. Required: records idx 3, 7, 200, all hit=1, row 0x0012, last only on 200. hit_count reads 3 afterward; in_ready returns to 1 the next cycle.
- Zero vector, row 0x00FF. Required: exactly one record with hit=0, idx=0, last=1. hit_count=0; returns to IDLE after the handshake.
- Bits {5,9} set; out_ready held low for 5 cycles after out_valid rises. Required: idx=5, hit=1, last=0 stable for all 5 cycles; then 5 and 9 delivered on consecutive cycles.
- num_row_elements=8, all-ones vector. Required: 8 back-to-back records idx 0..7, last only on 7, hit_count=8.
- Second in_valid asserted during SCAN of row A with 4 hits. Required: in_ready=0 throughout the scan. Row B is accepted in the IDLE cycle after row A's last record, and its first record follows one cycle later.
- Bits {1,2,3}; rst pulsed for one cycle after the first record's handshake. Required: out_valid=0 during reset, no idx 2 or 3 records emitted, hit_count=0, in_ready=1 the cycle after reset.
